// File: rtl/fifo_row_gather.sv
// fifo_row_gather: drains a valid/yumi FIFO head and packs els_p consecutive
// words into one row (word 0 in the low slot), offered with ready/valid.
// One word per cycle is sustained, including across row boundaries.
// Optional feature: define ROW_GATHER_FLUSH_EN to let flush_i close a partial
// row early (unfilled upper slots read as zero). Without it flush_i is ignored.
module fifo_row_gather #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       yumi_o,
    input  logic                       flush_i,
    output logic                       valid_o,
    output logic [els_p*width_p-1:0]   data_o,
    input  logic                       ready_i
);

    localparam int cnt_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(els_p - 1);

    typedef enum logic {FILL, FULL} state_e;

    state_e                     state_r, state_n;
    logic [cnt_w_lp-1:0]        cnt_r, cnt_n;
    logic [els_p*width_p-1:0]   row_r, row_n;

`ifdef ROW_GATHER_FLUSH_EN
    logic [cnt_w_lp:0]          fill_end;
`else
    logic                       unused_flush;
    assign unused_flush = flush_i;
`endif

    // Pop the FIFO whenever a word is present and there is room for it:
    // always while collecting, or while full only if the row leaves this cycle.
    assign yumi_o  = valid_i & ~reset_i & ((state_r == FILL) | ready_i);
    assign valid_o = (state_r == FULL);
    assign data_o  = row_r;

    // Next-state, slot counter and row contents.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        row_n   = row_r;
`ifdef ROW_GATHER_FLUSH_EN
        fill_end = '0;
`endif

        // cnt_r is always 0 in FULL, so an accepted word always lands in slot cnt_r.
        if (yumi_o) begin
            row_n[cnt_r*width_p +: width_p] = data_i;
        end

        if (state_r == FILL) begin
            if (yumi_o) begin
                if (cnt_r == last_lp) begin
                    cnt_n   = '0;
                    state_n = FULL;
                end else begin
                    cnt_n = cnt_r + 1'b1;
                end
            end
`ifdef ROW_GATHER_FLUSH_EN
            // A completing word already closes the row; otherwise close it
            // early as long as it would hold at least one word.
            fill_end = {1'b0, cnt_r} + (cnt_w_lp + 1)'(yumi_o);
            if (flush_i && (cnt_r != '0 || yumi_o) && !(yumi_o && cnt_r == last_lp)) begin
                for (int unsigned k = 0; k < els_p; k++) begin
                    if (k >= 32'(fill_end)) begin
                        row_n[k*width_p +: width_p] = '0;
                    end
                end
                cnt_n   = '0;
                state_n = FULL;
            end
`endif
        end else if (ready_i) begin
            // Row handed off; a word taken in the same cycle starts the next row.
            if (yumi_o) begin
                if (els_p == 1) begin
                    cnt_n   = '0;
                    state_n = FULL;
                end else begin
                    cnt_n   = cnt_w_lp'(1);
                    state_n = FILL;
                end
            end else begin
                state_n = FILL;
            end
        end
    end

    // State, counter and row registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= FILL;
            cnt_r   <= '0;
            row_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            row_r   <= row_n;
        end
    end

endmodule

// File: tb/tb_fifo_row_gather.sv
// Testbench for fifo_row_gather (width_p=8, els_p=4): directed scenarios with
// literal expectations, then randomized traffic, all checked every cycle
// against a queue-based model of row packing.
// Honours ROW_GATHER_FLUSH_EN the same way as the design.
module tb_fifo_row_gather;

    localparam int W = 8;
    localparam int E = 4;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             valid_i = 1'b0;
    logic [W-1:0]     data_i = '0;
    logic             yumi_o;
    logic             flush_i = 1'b0;
    logic             valid_o;
    logic [E*W-1:0]   data_o;
    logic             ready_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_row_gather #(.width_p(W), .els_p(E)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .yumi_o  (yumi_o),
        .flush_i (flush_i),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0]   words[$];
    logic           m_full = 1'b0;
    logic [E*W-1:0] m_row  = '0;

    function automatic logic [E*W-1:0] pack(input logic [W-1:0] q[$]);
        logic [E*W-1:0] r;
        r = '0;
        foreach (q[i]) r[i*W +: W] = q[i];
        return r;
    endfunction

    // Compare at the falling edge, advance the model at the rising edge.
    initial begin
        logic was_full, y;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                words.delete();
                m_full = 1'b0;
                check("reset_valid", valid_o, 1'b0);
                check("reset_yumi", yumi_o, 1'b0);
                check("reset_data", data_o, '0);
            end else begin
                check("yumi", yumi_o, valid_i & (~m_full | ready_i));
                check("valid", valid_o, m_full);
                if (m_full) check("row", data_o, m_row);
            end
            @(posedge clk);
            if (reset_i) begin
                words.delete();
                m_full = 1'b0;
            end else begin
                was_full = m_full;
                y = valid_i & (~was_full | ready_i);
                if (was_full && ready_i) m_full = 1'b0;
                if (y) words.push_back(data_i);
                if (words.size() == E) begin
                    m_row = pack(words);
                    m_full = 1'b1;
                    words.delete();
                end
`ifdef ROW_GATHER_FLUSH_EN
                else if (!was_full && flush_i && words.size() != 0) begin
                    m_row = pack(words);
                    m_full = 1'b1;
                    words.delete();
                end
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset held with a word offered: nothing consumed
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        tick();
        #1;
        check("lit_reset_yumi", yumi_o, 1'b0);
        check("lit_reset_valid", valid_o, 1'b0);
        tick();
        reset_i = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();

        // first row, valid_o one cycle after the last word
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0);
            tick();
            if (i == 3) check("lit_not_yet_valid", valid_o, 1'b0);
        end
        check("lit_row1_valid", valid_o, 1'b1);
        check("lit_row1_data", data_o, 32'h04030201);

        // backpressure: held row, no pops, then pop in the release cycle
        drive(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("lit_bp_yumi", yumi_o, 1'b0);
            check("lit_bp_data", data_o, 32'h04030201);
            tick();
        end
        drive(1'b1, 8'h55, 1'b1, 1'b0);
        #1;
        check("lit_release_yumi", yumi_o, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(8'h66 + 8'h11 * i), 1'b0, 1'b0);
            tick();
        end
        check("lit_zero_bubble_row", data_o, 32'h88776655);

        // asynchronous reset mid-cycle while a row is held
        drive(1'b1, 8'h99, 1'b1, 1'b0);
        reset_i = 1'b1;
        #1;
        check("lit_async_valid", valid_o, 1'b0);
        check("lit_async_yumi", yumi_o, 1'b0);
        check("lit_async_data", data_o, '0);
        tick();
        reset_i = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();

        // streaming with ready always high
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            #1;
            check("lit_stream_yumi", yumi_o, 1'b1);
            tick();
            if (i == 4) check("lit_stream_row1", data_o, 32'h04030201);
            if (i == 8) check("lit_stream_row2", data_o, 32'h08070605);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // gaps on valid_i
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1'b1, W'(8'h0A + i / 2), 1'b0, 1'b0);
            else            drive(1'b0, 8'hEE, 1'b0, 1'b0);
            #1;
            check("lit_gap_yumi", yumi_o, (i % 2 == 0) ? 1'b1 : 1'b0);
            tick();
        end
        check("lit_gap_row", data_o, 32'h0D0C0B0A);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // flush of a partial row
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
`ifdef ROW_GATHER_FLUSH_EN
        check("lit_flush_valid", valid_o, 1'b1);
        check("lit_flush_row", data_o, 32'h00002211);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        check("lit_flush_empty", valid_o, 1'b0);
`else
        check("lit_noflush_valid", valid_o, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        tick();
        check("lit_noflush_valid3", valid_o, 1'b0);
        drive(1'b1, 8'h44, 1'b0, 1'b0);
        tick();
        check("lit_noflush_row", data_o, 32'h44332211);
`endif
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // reset mid-row discards the partial row
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0);
            tick();
        end
        check("lit_reset_midrow_row", data_o, 32'h08070605);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset_i = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, W'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
            tick();
        end
        reset_i = 1'b0;
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
